dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   SZ_*      : funct3 access-size codes
//   lane_sel  : byte-enable mask for an access size and byte offset
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Little-endian lane mask. Illegal codes give an empty mask.
  function automatic logic [3:0] lane_sel(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_B, SZ_BU: mask = 4'b0001 << addr_lo;
      SZ_H, SZ_HU: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between the bus and a 32-bit storage word.
// Ports:
//   size      : funct3 access code
//   addr_lo   : byte offset within the word
//   wdata     : right-aligned store data
//   rword     : storage word being read
//   byte_en   : lanes a store updates
//   wdata_rep : store data replicated onto every candidate lane
//   rdata_ext : selected load data, sign- or zero-extended to 32 bits
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    byte_en = lane_sel(size, addr_lo);

    // Replicating the data lets byte_en alone pick which lanes are written.
    wdata_rep = wdata;
    case (size)
      SZ_B, SZ_BU: wdata_rep = {4{wdata[7:0]}};
      SZ_H, SZ_HU: wdata_rep = {2{wdata[15:0]}};
      default:     wdata_rep = wdata;
    endcase

    rbyte = 8'h00;
    case (addr_lo)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = 8'h00;
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    rdata_ext = 32'h0;
    case (size)
      SZ_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
      SZ_BU:   rdata_ext = {24'h0, rbyte};
      SZ_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
      SZ_HU:   rdata_ext = {16'h0, rhalf};
      SZ_W:    rdata_ext = rword;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder with a valid/ready request channel and
// a valid/ready response channel.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_we, req_size         : store flag, funct3 size code
//   req_addr, req_wdata      : byte address, right-aligned store data
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata, rsp_err       : extended load data (0 on store/error), fault flag
//   dbg_state                : current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE. The response (rsp_valid, rsp_rdata,
// rsp_err) holds steady in RESP until the edge where rsp_ready is 1.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [MEM_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        cur_we;
  logic [2:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        in_range;
  logic        access_err;
  logic [IDX_W-1:0] idx;
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic [31:0] load_val;

  assign accept    = req_valid && (state == ST_IDLE);
  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;

  // With no wait states the access happens on the accept edge itself, before
  // the request registers are loaded, so it must use the live request.
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));

  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = req_we;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = r_we;
      cur_size  = r_size;
      cur_addr  = r_addr;
      cur_wdata = r_wdata;
    end
  end

  // Full 30-bit word index compared against the array size so that
  // out-of-range addresses fault instead of aliasing onto low words.
  assign in_range = ({2'b00, cur_addr[31:2]} < 32'(MEM_WORDS));
  assign idx      = cur_addr[IDX_W+1:2];
  assign rword    = mem[idx];

  always_comb begin
    access_err = 1'b0;
    case (cur_size)
      SZ_B:        access_err = 1'b0;
      SZ_H:        access_err = cur_addr[0];
      SZ_W:        access_err = (cur_addr[1:0] != 2'b00);
      SZ_BU:       access_err = cur_we;
      SZ_HU:       access_err = cur_we || cur_addr[0];
      default:     access_err = 1'b1;
    endcase
    if (!in_range) access_err = 1'b1;
  end

  dmem_lane_align u_align (
    .size      (cur_size),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  assign load_val = (access_err || cur_we) ? 32'h0 : rdata_ext;

  // Storage has no reset; a reset in WAIT simply never reaches the write edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_val;
              rsp_err   <= access_err;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_val;
            rsp_err   <= access_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states and 1024 words,
// one with no wait states and 16 words, sharing the request bus.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int WORDS_A = 1024;
  localparam int WORDS_B = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared bus / per-DUT gating ----------------
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_dbg_state;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [1:0]  b_dbg_state;

  dmem_responder #(.MEM_WORDS(WORDS_A), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .dbg_state(a_dbg_state)
  );

  dmem_responder #(.MEM_WORDS(WORDS_B), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .dbg_state(b_dbg_state)
  );

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_a [WORDS_A];
  logic [31:0] mdl_b [WORDS_B];

  task automatic model_access(input logic s, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata);
    int nbytes;
    int lo;
    int words;
    logic [31:0] word;
    logic [31:0] wi;
    words = s ? WORDS_B : WORDS_A;
    lo = int'(addr % 4);
    wi = addr >> 2;
    case (size)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    nbytes = 0;
    endcase
    err = 1'b0;
    if (nbytes == 0) err = 1'b1;
    if (we && (size == 3'd4 || size == 3'd5)) err = 1'b1;
    if (nbytes == 2 && (addr % 2) != 0) err = 1'b1;
    if (nbytes == 4 && lo != 0) err = 1'b1;
    if (wi >= 32'(words)) err = 1'b1;
    rdata = 32'h0;
    if (!err) begin
      word = s ? mdl_b[wi] : mdl_a[wi];
      if (we) begin
        for (int i = 0; i < nbytes; i++) begin
          word = (word & ~(32'hFF << (8 * (lo + i)))) |
                 (((wdata >> (8 * i)) & 32'hFF) << (8 * (lo + i)));
        end
        if (s) mdl_b[wi] = word; else mdl_a[wi] = word;
      end else begin
        for (int i = 0; i < nbytes; i++)
          rdata = rdata | (((word >> (8 * (lo + i))) & 32'hFF) << (8 * i));
        if (size == 3'd0 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
        if (size == 3'd1 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic s, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, output logic [31:0] got_rdata,
                           output logic got_err);
    logic        e_err;
    logic [31:0] e_rdata;
    logic [32:0] e;
    int k;
    int wc;
    wc = s ? 0 : 2;
    model_access(s, we, size, addr, wdata, e_err, e_rdata);
    exp_q.push_back({e_err, e_rdata});

    @(negedge clk);
    sel = s; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check_val("req_ready_idle", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble the bus: the responder must work from what it latched.
    req_we = 1'($urandom); req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;

    k = 1;
    @(negedge clk);
    while (!o_rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("latency", 32'(k), 32'(wc + 1));

    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_val("hold_valid", 32'(o_rsp_valid), 32'd1);
      check_val("hold_rdata", o_rsp_rdata, e[31:0]);
      check_val("hold_err", 32'(o_rsp_err), 32'(e[32]));
      check_val("hold_req_ready", 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_val("rsp_rdata", o_rsp_rdata, e[31:0]);
    check_val("rsp_err", 32'(o_rsp_err), 32'(e[32]));
    got_rdata = o_rsp_rdata;
    got_err   = o_rsp_err;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_val("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_val("idle_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd;
  logic        er;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_a_req_ready", 32'(a_req_ready), 32'd1);
    check_val("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_val("rst_a_rdata", a_rsp_rdata, 32'h0);
    check_val("rst_a_err", 32'(a_rsp_err), 32'd0);
    check_val("rst_a_state", 32'(a_dbg_state), 32'(ST_IDLE));
    check_val("rst_b_req_ready", 32'(b_req_ready), 32'd1);
    check_val("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);

    // Give every word a known value so loads are fully predictable.
    for (int i = 0; i < WORDS_A; i++) do_access(1'b0, 1'b1, SZ_W, 32'(4 * i), $urandom, 0, rd, er);
    for (int i = 0; i < WORDS_B; i++) do_access(1'b1, 1'b1, SZ_W, 32'(4 * i), $urandom, 0, rd, er);

    // Directed cases on the two-wait-state instance.
    do_access(1'b0, 1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check_val("sw_err", 32'(er), 32'd0);
    do_access(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 0, rd, er);
    check_val("lw_10", rd, 32'hDEADBEEF);
    do_access(1'b0, 1'b0, SZ_B, 32'h13, 32'h0, 0, rd, er);
    check_val("lb_13", rd, 32'hFFFFFFDE);
    do_access(1'b0, 1'b0, SZ_BU, 32'h13, 32'h0, 0, rd, er);
    check_val("lbu_13", rd, 32'h000000DE);
    do_access(1'b0, 1'b0, SZ_H, 32'h12, 32'h0, 0, rd, er);
    check_val("lh_12", rd, 32'hFFFFDEAD);
    do_access(1'b0, 1'b1, SZ_B, 32'h11, 32'h55, 0, rd, er);
    do_access(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 0, rd, er);
    check_val("lw_after_sb", rd, 32'hDEAD55EF);
    do_access(1'b0, 1'b0, SZ_W, 32'h12, 32'h0, 0, rd, er);
    check_val("lw_misalign_err", 32'(er), 32'd1);
    check_val("lw_misalign_rdata", rd, 32'h0);
    do_access(1'b0, 1'b1, SZ_H, 32'h11, 32'hAAAA, 0, rd, er);
    check_val("sh_misalign_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 0, rd, er);
    check_val("lw_unchanged", rd, 32'hDEAD55EF);
    do_access(1'b0, 1'b0, SZ_W, 32'(4 * WORDS_A), 32'h0, 0, rd, er);
    check_val("lw_oob_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b1, SZ_W, 32'h8000_0000, 32'h1, 0, rd, er);
    check_val("sw_far_err", 32'(er), 32'd1);
    do_access(1'b0, 1'b0, SZ_W, 32'h10, 32'h0, 5, rd, er);
    check_val("lw_held", rd, 32'hDEAD55EF);

    // Zero-wait instance.
    do_access(1'b1, 1'b1, SZ_H, 32'h6, 32'hBEEF, 2, rd, er);
    do_access(1'b1, 1'b0, SZ_HU, 32'h6, 32'h0, 0, rd, er);
    check_val("b_lhu", rd, 32'h0000BEEF);
    do_access(1'b1, 1'b0, SZ_W, 32'(4 * WORDS_B), 32'h0, 0, rd, er);
    check_val("b_oob_err", 32'(er), 32'd1);

    // Reset during WAIT abandons the store.
    do_access(1'b0, 1'b1, SZ_W, 32'h20, 32'hCAFEF00D, 0, rd, er);
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rstwait_req_ready", 32'(a_req_ready), 32'd1);
    check_val("rstwait_state", 32'(a_dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      check_val("rstwait_no_rsp", 32'(a_rsp_valid), 32'd0);
      @(negedge clk);
    end
    do_access(1'b0, 1'b0, SZ_W, 32'h20, 32'h0, 0, rd, er);
    check_val("rstwait_old_value", rd, 32'hCAFEF00D);

    // Randomized traffic across both instances, all size codes.
    for (int n = 0; n < 400; n++) begin
      logic        s;
      logic [31:0] a;
      s = 1'($urandom);
      if (s) a = 32'($urandom_range(0, WORDS_B + 3) * 4 + $urandom_range(0, 3));
      else   a = 32'($urandom_range(0, WORDS_A + 40) * 4 + $urandom_range(0, 3));
      do_access(s, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                $urandom_range(0, 3), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
